hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the stall and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three event types: load-use hazards, EX-stage control redirects, and data-memory wait states.
- A 3-state FSM bounds data-memory waits with a timeout. A saturating counter records stall cycles for performance analysis.

Parameters:
- MEM_TIMEOUT, 16, maximum consecutive data-memory stall cycles before halting. Legal range is >= 2.
- CNT_W, 16, width of the stall_cycles performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous, active-low reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_uses_rs1  in  1  the ID instruction reads rs1.
- id_uses_rs2  in  1  the ID instruction reads rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_to_reg  in  1  the EX instruction is a load.
- ex_reg_wr_en  in  1  the EX instruction writes rd.
- ex_redirect  in  1  a taken branch or jump is resolved in EX this cycle.
- mem_req  in  1  the MEM-stage instruction accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_stall  out  1  hold the PC.
- if_id_stall, if_id_flush  out  1 each  IF/ID register control.
- id_ex_stall, id_ex_flush  out  1 each  ID/EX register control.
- ex_mem_stall, ex_mem_flush  out  1 each  EX/MEM register control.
- mem_wb_stall, mem_wb_flush  out  1 each  MEM/WB register control.
- mem_timeout_err  out  1  sticky error; the pipeline is halted.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state<=RUN, wait_cnt<=0, stall_cycles<=0, mem_timeout_err<=0.
  - While rst_n=0, every stall/flush output is forced to 0 combinationally.
  - A reset asserted during MEM_WAIT or HALT returns the block to RUN on the next edge.
- Stall/flush outputs are combinational from the current state and inputs (zero latency). The state, wait_cnt, the error flag and the counter are registered.
- Downstream pipeline registers give flush priority over stall; this block never asserts both on the same register.
- Load-use hazard (load_use) is true when all of the following hold:
  - ex_mem_to_reg=1 and ex_reg_wr_en=1 and ex_rd!=0;
  - (id_uses_rs1=1 and id_rs1==ex_rd) or (id_uses_rs2=1 and id_rs2==ex_rd).
- Memory stall (mem_stall) is true when mem_req=1 and dmem_ready=0, in RUN or MEM_WAIT.
- Output priority, highest first:
  1. HALT: all *_stall=1, all *_flush=0, mem_timeout_err=1.
  2. mem_stall: pc/if_id/id_ex/ex_mem stall=1, mem_wb_flush=1 (bubble into WB), mem_wb_stall=0. Any redirect or load-use this cycle is ignored; upstream stages are frozen, so it is re-evaluated after release.
  3. ex_redirect: if_id_flush=1, id_ex_flush=1, no stalls. This overrides load_use because the ID instruction is wrong-path.
  4. load_use: pc_stall=1, if_id_stall=1, id_ex_flush=1 (one bubble). All other outputs are 0.
  5. Otherwise all stall/flush outputs are 0.
- FSM transitions:
  - RUN: if mem_stall, go to MEM_WAIT with wait_cnt<=1. Otherwise stay in RUN.
  - MEM_WAIT, dmem_ready=1: go to RUN with wait_cnt<=0. In that cycle the stalls drop and the priority logic evaluates normally.
  - MEM_WAIT, dmem_ready=0 and wait_cnt==MEM_TIMEOUT-1: go to HALT. This is the MEM_TIMEOUT-th stall cycle.
  - MEM_WAIT, otherwise: wait_cnt<=wait_cnt+1.
  - MEM_WAIT, mem_req drops while not ready: go to RUN, wait_cnt<=0 (protocol violation, tolerated).
  - HALT: terminal until reset.
- stall_cycles increments on every cycle with pc_stall=1 and saturates at all-ones (no wrap).

Test Plan:
- Load-use:
  - Stimulus: EX holds a load with ex_rd=5; ID has id_rs1=5, id_uses_rs1=1.
  - Expected: pc_stall=if_id_stall=id_ex_flush=1 for exactly 1 cycle, stall_cycles=1.
  - Repeat with ex_rd=0 or id_uses_rs1=0: no stall.
- Redirect plus load-use in the same cycle:
  - Expected: only if_id_flush and id_ex_flush are 1, with no stall.
- Memory wait:
  - Stimulus: mem_req=1, dmem_ready=0 for 3 cycles, then 1.
  - Expected: upper stalls and mem_wb_flush=1 for 3 cycles, state returns to RUN, stall_cycles=3.
  - A concurrent ex_redirect during the wait is suppressed.
- Timeout with MEM_TIMEOUT=4:
  - Stimulus: mem_req=1, dmem_ready stuck at 0.
  - Expected: HALT entered after 4 stall cycles; mem_timeout_err=1 and all stalls=1 hold indefinitely.
  - Then rst_n=0 for 1 edge: all outputs return to 0 and state is RUN.
- Counter saturation with CNT_W=4:
  - Stimulus: 20 load-use stall cycles.
  - Expected: stall_cycles=15, no wrap.
- Reset mid-wait:
  - Stimulus: assert rst_n=0 while in MEM_WAIT with wait_cnt=2.
  - Expected: outputs are 0 during reset; after reset, wait_cnt restarts at 1 on the next miss.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencer with bounded data-memory waits and a stall-cycle counter
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_to_reg,
  input  logic             ex_reg_wr_en,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             ex_mem_flush,
  output logic             mem_wb_stall,
  output logic             mem_wb_flush,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic load_use, mem_stall;
  assign load_use = ex_mem_to_reg && ex_reg_wr_en && ex_rd != 5'd0 &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  assign mem_stall = mem_req && !dmem_ready && state != HALT;
  always_comb begin
    pc_stall = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_stall = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_stall = 1'b0;
    mem_wb_flush = 1'b0;
    if (rst_n) begin
      if (state == HALT) begin
        pc_stall = 1'b1;
        if_id_stall = 1'b1;
        id_ex_stall = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_stall = 1'b1;
      end else if (mem_stall) begin
        pc_stall = 1'b1;
        if_id_stall = 1'b1;
        id_ex_stall = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end
  always_comb begin
    state_nx = state;
    wait_nx = wait_cnt;
    if (state == RUN && mem_stall) begin
      state_nx = MEM_WAIT;
      wait_nx = WW'(1);
    end else if (state == MEM_WAIT) begin
      if (!mem_stall) begin
        state_nx = RUN;
        wait_nx = '0;
      end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
        state_nx = HALT;
      end else begin
        wait_nx = wait_cnt + WW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      wait_cnt <= '0;
      stall_cycles <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      wait_cnt <= wait_nx;
      if (state_nx == HALT) mem_timeout_err <= 1'b1;
      if (pc_stall && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven checks of hazard_ctrl with MEM_TIMEOUT=4, CNT_W=4
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_to_reg, ex_reg_wr_en, ex_redirect, mem_req, dmem_ready;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush, mem_timeout_err;
  logic [3:0] stall_cycles;
  int applied = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_wr_en(ex_reg_wr_en),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .mem_wb_stall(mem_wb_stall), .mem_wb_flush(mem_wb_flush),
    .mem_timeout_err(mem_timeout_err), .stall_cycles(stall_cycles)
  );
  // output bit order: pc, if_id stall/flush, id_ex stall/flush, ex_mem stall/flush, mem_wb stall/flush
  localparam logic [8:0] NONE = 9'b0_00_00_00_00;
  localparam logic [8:0] LU   = 9'b1_10_01_00_00;
  localparam logic [8:0] RD   = 9'b0_01_01_00_00;
  localparam logic [8:0] MS   = 9'b1_10_10_10_01;
  localparam logic [8:0] HL   = 9'b1_10_10_10_10;
  typedef struct {
    logic rst_n;
    logic [4:0] rs1, rs2;
    logic u1, u2;
    logic [4:0] rd;
    logic m2r, wr, redir, mreq, rdy;
    logic [8:0] out;
    logic err;
    logic [3:0] cnt;
  } vec_t;
  vec_t tbl[32];
  function automatic vec_t mk(logic r, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic [4:0] rd, logic m2r, logic wr, logic redir, logic mreq,
                              logic rdy, logic [8:0] out, logic err, logic [3:0] cnt);
    vec_t v;
    v.rst_n = r; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.m2r = m2r; v.wr = wr; v.redir = redir; v.mreq = mreq; v.rdy = rdy;
    v.out = out; v.err = err; v.cnt = cnt;
    return v;
  endfunction
  task automatic apply(input vec_t v, input string name);
    logic [8:0] got;
    @(negedge clk);
    rst_n = v.rst_n; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    ex_rd = v.rd; ex_mem_to_reg = v.m2r; ex_reg_wr_en = v.wr; ex_redirect = v.redir;
    mem_req = v.mreq; dmem_ready = v.rdy;
    #1;
    got = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush};
    applied++;
    if (got !== v.out || mem_timeout_err !== v.err || stall_cycles !== v.cnt) begin
      errors++;
      $display("FAIL %s: got out=%b err=%b cnt=%0d, expected out=%b err=%b cnt=%0d",
               name, got, mem_timeout_err, stall_cycles, v.out, v.err, v.cnt);
    end
  endtask
  initial begin
    tbl[0]  = mk(0, 5,0,1,0, 5,1,1, 0, 0,0, NONE, 0, 0);
    tbl[1]  = mk(1, 0,0,0,0, 0,0,0, 0, 0,0, NONE, 0, 0);
    tbl[2]  = mk(1, 5,0,1,0, 5,1,1, 0, 0,0, LU,   0, 0);
    tbl[3]  = mk(1, 0,0,0,0, 0,0,0, 0, 0,0, NONE, 0, 1);
    tbl[4]  = mk(1, 0,0,1,0, 0,1,1, 0, 0,0, NONE, 0, 1);
    tbl[5]  = mk(1, 5,0,0,0, 5,1,1, 0, 0,0, NONE, 0, 1);
    tbl[6]  = mk(1, 0,7,0,1, 7,1,1, 0, 0,0, LU,   0, 1);
    tbl[7]  = mk(1, 5,0,1,0, 5,1,0, 0, 0,0, NONE, 0, 2);
    tbl[8]  = mk(1, 5,0,1,0, 5,0,1, 0, 0,0, NONE, 0, 2);
    tbl[9]  = mk(1, 5,0,1,0, 5,1,1, 1, 0,0, RD,   0, 2);
    tbl[10] = mk(1, 0,0,0,0, 0,0,0, 1, 0,0, RD,   0, 2);
    tbl[11] = mk(0, 0,0,0,0, 0,0,0, 0, 0,0, NONE, 0, 2);
    tbl[12] = mk(1, 0,0,0,0, 0,0,0, 0, 1,0, MS,   0, 0);
    tbl[13] = mk(1, 5,0,1,0, 5,1,1, 1, 1,0, MS,   0, 1);
    tbl[14] = mk(1, 0,0,0,0, 0,0,0, 0, 1,0, MS,   0, 2);
    tbl[15] = mk(1, 0,0,0,0, 0,0,0, 1, 1,1, RD,   0, 3);
    tbl[16] = mk(1, 0,0,0,0, 0,0,0, 0, 0,0, NONE, 0, 3);
    tbl[17] = mk(1, 0,0,0,0, 0,0,0, 0, 1,0, MS,   0, 3);
    tbl[18] = mk(1, 0,0,0,0, 0,0,0, 0, 1,0, MS,   0, 4);
    tbl[19] = mk(0, 0,0,0,0, 0,0,0, 0, 1,0, NONE, 0, 5);
    tbl[20] = mk(1, 0,0,0,0, 0,0,0, 0, 1,0, MS,   0, 0);
    tbl[21] = mk(1, 0,0,0,0, 0,0,0, 0, 1,0, MS,   0, 1);
    tbl[22] = mk(1, 0,0,0,0, 0,0,0, 0, 1,0, MS,   0, 2);
    tbl[23] = mk(1, 0,0,0,0, 0,0,0, 0, 1,0, MS,   0, 3);
    tbl[24] = mk(1, 0,0,0,0, 0,0,0, 0, 1,0, HL,   1, 4);
    tbl[25] = mk(1, 0,0,0,0, 0,0,0, 0, 0,0, HL,   1, 5);
    tbl[26] = mk(1, 0,0,0,0, 0,0,0, 1, 1,1, HL,   1, 6);
    tbl[27] = mk(0, 0,0,0,0, 0,0,0, 0, 0,0, NONE, 1, 7);
    tbl[28] = mk(1, 0,0,0,0, 0,0,0, 0, 0,0, NONE, 0, 0);
    tbl[29] = mk(1, 0,0,0,0, 0,0,0, 0, 1,0, MS,   0, 0);
    tbl[30] = mk(1, 5,0,1,0, 5,1,1, 0, 0,0, LU,   0, 1);
    tbl[31] = mk(1, 0,0,0,0, 0,0,0, 0, 0,0, NONE, 0, 2);
    rst_n = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = '0; ex_mem_to_reg = 1'b0; ex_reg_wr_en = 1'b0; ex_redirect = 1'b0;
    mem_req = 1'b0; dmem_ready = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 32; i++) apply(tbl[i], $sformatf("row%0d", i));
    for (int i = 0; i < 20; i++)
      apply(mk(1, 5,0,1,0, 5,1,1, 0, 0,0, LU, 0, 4'((2 + i > 15) ? 15 : 2 + i)), $sformatf("sat%0d", i));
    apply(mk(1, 0,0,0,0, 0,0,0, 0, 0,0, NONE, 0, 15), "sat_hold");
    apply(mk(0, 0,0,0,0, 0,0,0, 0, 0,0, NONE, 0, 15), "rst_b");
    for (int i = 0; i < 4; i++)
      apply(mk(1, 0,0,0,0, 0,0,0, 0, 1,0, MS, 0, 4'(i)), $sformatf("to_wait%0d", i));
    for (int i = 0; i < 12; i++)
      apply(mk(1, 0,0,0,0, 0,0,0, 0, 1,0, HL, 1, 4'((4 + i > 15) ? 15 : 4 + i)), $sformatf("halt%0d", i));
    apply(mk(0, 0,0,0,0, 0,0,0, 0, 1,0, NONE, 1, 15), "halt_rst");
    apply(mk(1, 0,0,0,0, 0,0,0, 0, 0,0, NONE, 0, 0), "post_rst");
    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end
endmodule
